// File: rtl/expr_hammer_pkg.sv
// Shared types and helpers for the expression-result MISR slice.
package expr_hammer_pkg;

  localparam int          MISR_W   = 32;
  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One Galois MISR step: shift left, fold in the polynomial when the MSB
  // falls out, then absorb the new data word.
  function automatic logic [MISR_W-1:0] misr_step(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] din,
    input logic [MISR_W-1:0] poly
  );
    return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ din;
  endfunction

endpackage

// File: rtl/expr_fold.sv
// Combinational XOR folder: squeezes a Y_W-bit result vector to 32 bits.
module expr_fold #(
  parameter int Y_W = 90
) (
  input  logic [Y_W-1:0] y_data,
  output logic [31:0]    fold
);

  // Zero-extend to three full words so bits beyond Y_W contribute nothing.
  logic [95:0] ext;

  // XOR the three 32-bit words together.
  always_comb begin
    ext  = 96'(y_data);
    fold = ext[31:0] ^ ext[63:32] ^ ext[95:64];
  end

endmodule

// File: rtl/expr_result_misr.sv
// Result-bus compactor: folds each accepted vector to 32 bits, runs it through
// a MISR, and compares the final signature with a golden value.
module expr_result_misr
  import expr_hammer_pkg::*;
#(
  parameter int          Y_W         = 90,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = DEF_SEED,
  parameter logic [31:0] POLY        = DEF_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_valid,
  output logic             y_ready,
  input  logic [Y_W-1:0]   y_data,
  input  logic [31:0]      exp_sig,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [31:0]      signature,
  output logic [15:0]      count
);

  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);

  state_t      state;
  logic        fold_v;
  logic [31:0] fold_q;
  logic [31:0] fold;
  logic [31:0] sig_next;
  logic        acc;

  expr_fold #(.Y_W(Y_W)) u_fold (
    .y_data (y_data),
    .fold   (fold)
  );

  // Handshake and the value the MISR will hold after this edge.
  always_comb begin
    acc      = y_valid & y_ready;
    sig_next = fold_v ? misr_step(signature, fold_q, POLY) : signature;
  end

  // Fold pipeline, MISR update and run-control FSM; the FSM's reseed on start
  // is written last so it overrides the pipeline assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      signature <= SEED;
      count     <= '0;
      fold_v    <= 1'b0;
      fold_q    <= '0;
      done      <= 1'b0;
      match     <= 1'b0;
      busy      <= 1'b0;
      y_ready   <= 1'b0;
    end else begin
      fold_v    <= acc;
      signature <= sig_next;
      if (acc) begin
        fold_q <= fold;
        count  <= count + 16'd1;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            signature <= SEED;
            count     <= '0;
            match     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            y_ready   <= 1'b1;
          end
        end
        RUN: begin
          if (acc && count == LAST) begin
            state   <= DRAIN;
            y_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // The last folded word lands in the signature on this edge.
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          match <= (sig_next == exp_sig);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_result_misr.sv
// Directed bench for expr_result_misr: three instances cover the single-vector
// seed cases and a four-vector run with handshake gaps.
module tb_expr_result_misr;

  logic        clk = 1'b0;
  logic        rst;
  logic        start   [3];
  logic        y_valid [3];
  logic        y_ready [3];
  logic [89:0] y_data  [3];
  logic [31:0] exp_sig [3];
  logic        busy    [3];
  logic        done    [3];
  logic        match   [3];
  logic [31:0] signature [3];
  logic [15:0] count   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: NUM_VECTORS=1, SEED=FFFFFFFF
  expr_result_misr #(.Y_W(90), .NUM_VECTORS(1), .SEED(32'hFFFFFFFF)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .y_valid(y_valid[0]), .y_ready(y_ready[0]),
    .y_data(y_data[0]), .exp_sig(exp_sig[0]), .busy(busy[0]), .done(done[0]),
    .match(match[0]), .signature(signature[0]), .count(count[0]));

  // 1: NUM_VECTORS=1, SEED=0
  expr_result_misr #(.Y_W(90), .NUM_VECTORS(1), .SEED(32'h00000000)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .y_valid(y_valid[1]), .y_ready(y_ready[1]),
    .y_data(y_data[1]), .exp_sig(exp_sig[1]), .busy(busy[1]), .done(done[1]),
    .match(match[1]), .signature(signature[1]), .count(count[1]));

  // 2: NUM_VECTORS=4, SEED=FFFFFFFF
  expr_result_misr #(.Y_W(90), .NUM_VECTORS(4), .SEED(32'hFFFFFFFF)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .y_valid(y_valid[2]), .y_ready(y_ready[2]),
    .y_data(y_data[2]), .exp_sig(exp_sig[2]), .busy(busy[2]), .done(done[2]),
    .match(match[2]), .signature(signature[2]), .count(count[2]));

  typedef struct {
    logic        v;
    logic [89:0] d;
    logic [15:0] ecnt;
    logic        erdy;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [31:0] mfold(input logic [89:0] d);
    logic [31:0] f = '0;
    for (int i = 0; i < 90; i++) f[i % 32] = f[i % 32] ^ d[i];
    return f;
  endfunction

  function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] f);
    logic [31:0] t = s << 1;
    if (s[31]) t = t ^ 32'h04C11DB7;
    return t ^ f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // One-vector run on instance k: start, one handshake, drain, done.
  task automatic one_run(input int k, input logic [89:0] d, input logic [31:0] es,
                         input logic [31:0] esig, input logic em, input string n);
    exp_sig[k] = es;
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    chk({n, " ready"}, 32'(y_ready[k]), 32'd1);
    y_valid[k] = 1'b1;
    y_data[k]  = d;
    tick();
    y_valid[k] = 1'b0;
    chk({n, " cnt"}, 32'(count[k]), 32'd1);
    chk({n, " ready_low"}, 32'(y_ready[k]), 32'd0);
    chk({n, " not_done_yet"}, 32'(done[k]), 32'd0);
    tick();
    chk({n, " done"}, 32'(done[k]), 32'd1);
    chk({n, " sig"}, signature[k], esig);
    chk({n, " match"}, 32'(match[k]), 32'(em));
  endtask

  logic [31:0] model;

  initial begin
    tbl[0] = '{1'b1, 90'h1234567_89ABCDEF_DEADBEEF, 16'd1, 1'b1};
    tbl[1] = '{1'b0, 90'h3FFFFFF_FFFFFFFF_FFFFFFFF, 16'd1, 1'b1};
    tbl[2] = '{1'b1, 90'h0000001_00000000_80000000, 16'd2, 1'b1};
    tbl[3] = '{1'b1, 90'h2AAAAAA_55555555_0F0F0F0F, 16'd3, 1'b1};
    tbl[4] = '{1'b0, 90'h0,                         16'd3, 1'b1};
    tbl[5] = '{1'b1, 90'h0000000_00000000_00000001, 16'd4, 1'b0};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; y_valid[k] = 1'b0; y_data[k] = '0; exp_sig[k] = '0;
    end
    tick(); tick();
    rst = 1'b0;

    chk("reset sig", signature[0], 32'hFFFFFFFF);
    chk("reset sig seed0", signature[1], 32'h00000000);
    chk("reset cnt", 32'(count[2]), 32'd0);
    chk("reset flags", {29'd0, y_ready[2], busy[2], done[2]}, 32'd0);

    // Single zero vector from the all-ones seed, then golden compare both ways.
    one_run(0, 90'h0, 32'hFB3EE249, 32'hFB3EE249, 1'b1, "nv1_hit");
    one_run(0, 90'h0, 32'hFB3EE248, 32'hFB3EE249, 1'b0, "nv1_miss");

    // Zero seed: bit 0 and bit 64 both fold to word value 1.
    one_run(1, 90'h1, 32'h1, 32'h00000001, 1'b1, "seed0_b0");
    one_run(1, 90'h1 << 64, 32'h0, 32'h00000001, 1'b0, "seed0_b64");

    // Four-vector run with valid gaps, table driven.
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    chk("nv4 busy", 32'(busy[2]), 32'd1);
    model = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      y_valid[2] = tbl[i].v;
      y_data[2]  = tbl[i].d;
      if (tbl[i].v) model = mstep(model, mfold(tbl[i].d));
      tick();
      chk($sformatf("nv4 cnt[%0d]", i), 32'(count[2]), 32'(tbl[i].ecnt));
      chk($sformatf("nv4 rdy[%0d]", i), 32'(y_ready[2]), 32'(tbl[i].erdy));
    end
    y_valid[2] = 1'b0;
    exp_sig[2] = model;
    tick();
    chk("nv4 done", 32'(done[2]), 32'd1);
    chk("nv4 sig", signature[2], model);
    chk("nv4 match", 32'(match[2]), 32'd1);
    chk("nv4 busy_low", 32'(busy[2]), 32'd0);

    // Reset in the middle of a run after two vectors.
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    y_valid[2] = 1'b1;
    y_data[2]  = 90'h5;
    tick(); tick();
    chk("mid cnt2", 32'(count[2]), 32'd2);
    y_valid[2] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst sig", signature[2], 32'hFFFFFFFF);
    chk("rst cnt", 32'(count[2]), 32'd0);
    chk("rst flags", {29'd0, y_ready[2], busy[2], done[2]}, 32'd0);

    // Clean run after reset; a start pulse during RUN must be ignored.
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    model = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      y_valid[2] = 1'b1;
      y_data[2]  = 90'(i * 32'h01010101 + 7);
      start[2]   = (i == 1);
      model = mstep(model, mfold(y_data[2]));
      tick();
    end
    start[2] = 1'b0;
    y_valid[2] = 1'b0;
    chk("rerun cnt", 32'(count[2]), 32'd4);
    exp_sig[2] = 32'h0;
    tick();
    chk("rerun done", 32'(done[2]), 32'd1);
    chk("rerun sig", signature[2], model);
    chk("rerun nomatch", 32'(match[2]), 32'd0);

    // Start from DONE reseeds.
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    chk("restart sig", signature[2], 32'hFFFFFFFF);
    chk("restart cnt", 32'(count[2]), 32'd0);
    chk("restart busy", 32'(busy[2]), 32'd1);
    chk("restart done", 32'(done[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
